// File: rtl/legv8_pc_pkg.sv
// rtl/legv8_pc_pkg.sv - shared types and constants for the LEGv8 program-counter unit
package legv8_pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_t;

    typedef enum logic [1:0] {
        SRC_SEQ    = 2'd0,
        SRC_HOLD   = 2'd1,
        SRC_BRANCH = 2'd2,
        SRC_EXC    = 2'd3
    } pc_src_t;

    localparam int         INSTR_BYTES_DEFAULT = 4;
    localparam logic [1:0] ALIGN_MASK          = 2'b11;

    function automatic logic is_aligned(input logic [1:0] addr_lo);
        return (addr_lo & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/legv8_pc_next_sel.sv
// rtl/legv8_pc_next_sel.sv - combinational next-pc source priority encoder
module legv8_pc_next_sel
    import legv8_pc_pkg::*;
(
    input  pc_state_t  i_state,
    input  logic       i_fetch_ready,
    input  logic       i_stall,
    input  logic       i_branch_taken,
    input  logic [1:0] i_target_lo,
    input  logic       i_exc_req,
    input  logic       i_halt_req,
    input  logic       i_resume,
    output pc_src_t    o_src,
    output logic       o_misalign,
    output logic       o_halt_enter,
    output logic       o_run_enter
);

    always_comb begin
        o_src        = SRC_HOLD;
        o_misalign   = 1'b0;
        o_halt_enter = 1'b0;
        o_run_enter  = 1'b0;
        case (i_state)
            ST_BOOT: begin
                o_run_enter = 1'b1;
            end
            ST_RUN: begin
                // Redirects outrank both halt and stall so they are never dropped.
                if (i_exc_req) begin
                    o_src = SRC_EXC;
                end else if (i_branch_taken) begin
                    if (is_aligned(i_target_lo)) begin
                        o_src = SRC_BRANCH;
                    end else begin
                        o_src      = SRC_EXC;
                        o_misalign = 1'b1;
                    end
                end else if (i_halt_req) begin
                    o_halt_enter = 1'b1;
                end else if (!i_stall && i_fetch_ready) begin
                    o_src = SRC_SEQ;
                end
            end
            ST_HALT: begin
                if (i_exc_req) begin
                    o_src       = SRC_EXC;
                    o_run_enter = 1'b1;
                end else if (i_resume) begin
                    o_run_enter = 1'b1;
                end
            end
            default: begin
                o_src = SRC_HOLD;
            end
        endcase
    end

endmodule

// File: rtl/legv8_pc_unit.sv
// rtl/legv8_pc_unit.sv - LEGv8 fetch program counter with stall, redirect, exception and halt
module legv8_pc_unit
    import legv8_pc_pkg::*;
#(
    parameter int          ADDR_W      = 64,
    parameter logic [63:0] RESET_ADDR  = 64'h0,
    parameter logic [63:0] EXC_VECTOR  = 64'h100,
    parameter int          INSTR_BYTES = INSTR_BYTES_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_ready,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              exc_req,
    input  logic              halt_req,
    input  logic              resume,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              pc_valid,
    output logic              misalign_fault
);

    localparam logic [ADDR_W-1:0] RESET_PC = RESET_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] EXC_PC   = EXC_VECTOR[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(INSTR_BYTES);

    if (ADDR_W < 8 || ADDR_W > 64) begin : g_bad_addr_w
        $error("legv8_pc_unit: ADDR_W must be in 8..64");
    end
    if (RESET_ADDR[1:0] != 2'b00) begin : g_bad_reset_addr
        $error("legv8_pc_unit: RESET_ADDR must be 4-byte aligned");
    end
    if (EXC_VECTOR[1:0] != 2'b00) begin : g_bad_exc_vector
        $error("legv8_pc_unit: EXC_VECTOR must be 4-byte aligned");
    end

    pc_state_t         r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_pc_valid;
    logic              r_misalign;

    pc_src_t           w_src;
    logic              w_misalign;
    logic              w_halt_enter;
    logic              w_run_enter;
    logic [ADDR_W-1:0] w_pc_plus;
    logic [ADDR_W-1:0] w_pc_next;

    legv8_pc_next_sel u_next_sel (
        .i_state        (r_state),
        .i_fetch_ready  (fetch_ready),
        .i_stall        (stall),
        .i_branch_taken (branch_taken),
        .i_target_lo    (branch_target[1:0]),
        .i_exc_req      (exc_req),
        .i_halt_req     (halt_req),
        .i_resume       (resume),
        .o_src          (w_src),
        .o_misalign     (w_misalign),
        .o_halt_enter   (w_halt_enter),
        .o_run_enter    (w_run_enter)
    );

    assign w_pc_plus = r_pc + STEP;

    always_comb begin
        w_pc_next = r_pc;
        case (w_src)
            SRC_SEQ:    w_pc_next = w_pc_plus;
            SRC_BRANCH: w_pc_next = branch_target;
            SRC_EXC:    w_pc_next = EXC_PC;
            default:    w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_pc_valid <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_misalign <= w_misalign;
            if (w_run_enter) begin
                r_state    <= ST_RUN;
                r_pc_valid <= 1'b1;
            end else if (w_halt_enter) begin
                r_state    <= ST_HALT;
                r_pc_valid <= 1'b0;
            end
        end
    end

    assign pc             = r_pc;
    assign pc_plus4       = w_pc_plus;
    assign pc_valid       = r_pc_valid;
    assign misalign_fault = r_misalign;

endmodule

// File: doc/legv8_pc_unit.md
Name: legv8_pc_unit

Overview:
Parametrised program-counter unit for the LEGv8 fetch stage.
- Holds the current fetch address and advances it by one instruction per accepted fetch.
- Supports stall, branch redirect, exception vectoring, halt/resume, and branch-target alignment checking.
- Sits between the branch-resolution/control logic and instruction memory, and drives the fetch address and a fetch-valid qualifier.

Parameters:
- ADDR_W, 64, address width in bits (legal range 8..64).
- RESET_ADDR, 0, PC value loaded on reset.
- EXC_VECTOR, 'h100, PC loaded on exception or misaligned branch; must be 4-byte aligned.
- INSTR_BYTES, 4, increment per sequential fetch.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_ready  in  1  instruction memory accepts pc this cycle.
- stall  in  1  pipeline hazard; hold pc.
- branch_taken  in  1  redirect request, valid for one cycle.
- branch_target  in  ADDR_W  redirect address.
- exc_req  in  1  exception request; redirect to EXC_VECTOR.
- halt_req  in  1  enter HALT.
- resume  in  1  leave HALT.
- pc  out  ADDR_W  current fetch address (registered).
- pc_plus4  out  ADDR_W  pc + INSTR_BYTES, combinational, modulo 2^ADDR_W; used for link register.
- pc_valid  out  1  pc is a live fetch request (registered).
- misalign_fault  out  1  one-cycle pulse: branch target was misaligned (registered).

Behaviour:
- Reset (synchronous, active-high, sampled at the clk edge):
  - pc = RESET_ADDR, pc_valid = 0, misalign_fault = 0, state = BOOT.
  - Reset overrides every other input in the same cycle.
- States: BOOT, RUN, HALT.
- BOOT:
  - Lasts exactly one cycle after reset deasserts, then goes to RUN.
  - pc is held. pc_valid becomes 1 on the edge entering RUN.
  - All requests are ignored in BOOT.
- RUN (pc_valid = 1). Next-pc priority, highest first:
  1. exc_req: pc <= EXC_VECTOR.
  2. branch_taken with branch_target[1:0] != 0: pc <= EXC_VECTOR; misalign_fault = 1 next cycle.
  3. branch_taken, aligned: pc <= branch_target.
  4. halt_req: pc held; state -> HALT; pc_valid = 0 next cycle.
  5. stall, or fetch_ready = 0: pc held.
  6. Otherwise: pc <= pc + INSTR_BYTES, wrapping modulo 2^ADDR_W (all-ones-minus-3 -> 0). No overflow flag.
- Redirect vs stall: a redirect (rows 1–3) is taken even when stall = 1 or fetch_ready = 0; it is never lost.
- Redirect vs halt: a redirect in the same cycle as halt_req wins; halt_req is dropped and must be re-asserted.
- HALT (pc_valid = 0, pc held):
  - exc_req: pc <= EXC_VECTOR, state -> RUN.
  - Else resume: state -> RUN; pc unchanged; pc_valid = 1 next cycle.
  - branch_taken and halt_req are ignored in HALT.
- misalign_fault is high for exactly one cycle per offending branch; otherwise 0.
- Latency: every input takes effect on pc exactly one clock after it is sampled.
- pc_plus4 tracks pc combinationally with zero latency.
- pc[1:0] is always 0 provided RESET_ADDR is aligned. A misaligned RESET_ADDR is an elaboration error (static assertion).

Decomposition:
- Package legv8_pc_pkg holds:
  - the state enum (BOOT, RUN, HALT);
  - INSTR_BYTES_DEFAULT;
  - the alignment-mask constant;
  - a next-pc-source enum (SEQ, HOLD, BRANCH, EXC).
- One natural sub-module: legv8_pc_next_sel, a combinational priority encoder implementing the RUN/HALT priority rules. It outputs the next-pc source and the misalign flag. The top level holds the registers and the FSM.

Test Plan:
1. Reset release, RESET_ADDR=0, fetch_ready=1, no requests -> BOOT one cycle; then pc = 0, 4, 8, 12 on successive cycles with pc_valid = 1; pc_plus4 = pc + 4.
2. At pc = 0x10, assert stall for 3 cycles, then fetch_ready = 0 for 2 cycles -> pc stays 0x10 for 5 cycles, then 0x14.
3. At pc = 0x20, branch_taken = 1, target = 0x400, stall = 1 simultaneously -> next pc = 0x400 (redirect beats stall), then 0x404.
4. branch_taken = 1, target = 0x402 -> next pc = EXC_VECTOR (0x100); misalign_fault = 1 for exactly one cycle.
5. exc_req and aligned branch_taken together -> pc = 0x100. Then halt_req -> pc_valid = 0 and pc held for 4 cycles despite branch_taken pulses. Then resume -> pc_valid = 1, pc advances from the held value.
6. ADDR_W = 8, pc = 0xFC, free-running -> next pc = 0x00 (wrap). Also assert reset mid-HALT -> pc = RESET_ADDR, pc_valid = 0, BOOT, then RUN.
